// File: rtl/ir_carrier_gen_pkg.sv
// Shared types and constants for the IR carrier generator.
package ir_carrier_gen_pkg;

    localparam int unsigned RESET_HALF  = 694;
    localparam int unsigned BURST_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic                   mark;
        logic [BURST_LEN_W-1:0] len;
    } burst_t;

endpackage

// File: rtl/ir_burst_fifo.sv
// Small burst queue; a pop frees the slot a same-cycle push may take, even when full.
module ir_burst_fifo
    import ir_carrier_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         rec_t = burst_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head_c,
    output logic empty,
    output logic full,
    output logic empty_next_c,
    output logic full_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop     = pop & (count != '0);
        do_push    = push & ((count != CNT_W'(DEPTH)) | do_pop);
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_push & ~do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop & ~do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign empty_next_c = (count_next == '0);
    assign full_next_c  = (count_next == CNT_W'(DEPTH));
    assign head_c       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            empty <= empty_next_c;
            full  <= full_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ir_carrier_gen.sv
// IR carrier generator: free-running square wave gated by a queue of mark/space bursts.
module ir_carrier_gen #(
    parameter int unsigned DIV_W      = 12,
    parameter int unsigned LEN_W      = ir_carrier_gen_pkg::BURST_LEN_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_HALF = ir_carrier_gen_pkg::RESET_HALF
) (
    input  logic             In_Clock,
    input  logic             In_Reset,
    input  logic             In_Enable,
    input  logic [DIV_W-1:0] In_Half_Div,
    input  logic             In_Burst_Valid,
    input  logic             In_Burst_Mark,
    input  logic [LEN_W-1:0] In_Burst_Len,
    output logic             Out_Burst_Ready,
    output logic             Out_Carrier,
    output logic             Out_Ir,
    output logic             Out_Busy
);

    import ir_carrier_gen_pkg::*;

    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] half_cnt;
    logic [DIV_W-1:0] half_eff;
    logic             phase;
    logic             phase_next;
    logic             wrap;
    logic             boundary;

    state_t           state;
    state_t           state_next;
    logic             mark_q;
    logic             mark_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] per_cnt;
    logic [LEN_W-1:0] per_next;

    logic             pop;
    logic             push;
    burst_t           head;
    burst_t           push_rec;
    logic             fifo_empty;
    logic             fifo_full;
    logic             empty_next;
    logic             full_next;

    logic             ready_q;
    logic             ir_q;
    logic             busy_q;

    // Carrier: a zero divider behaves as one so the counter always terminates.
    assign half_eff = (half_q == '0) ? DIV_W'(1) : half_q;
    assign wrap     = In_Enable & (half_cnt == half_eff - DIV_W'(1));
    assign boundary = wrap & ~phase;

    always_comb begin
        phase_next = phase;
        if (!In_Enable) begin
            phase_next = 1'b0;
        end else if (wrap) begin
            phase_next = ~phase;
        end
    end

    always_ff @(posedge In_Clock) begin
        if (In_Reset) begin
            half_q   <= DIV_W'(RESET_HALF);
            half_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            phase <= phase_next;
            if (!In_Enable || wrap) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + DIV_W'(1);
            end
            if (boundary) half_q <= In_Half_Div;
        end
    end

    assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;

    // Burst sequencer; a finishing burst hands over to the next one on the same boundary.
    always_comb begin
        state_next = state;
        mark_next  = mark_q;
        len_next   = len_q;
        per_next   = per_cnt;
        pop        = 1'b0;
        if (!In_Enable) begin
            state_next = IDLE;
            per_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        mark_next  = head.mark;
                        len_next   = LEN_W'(head.len);
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (boundary) begin
                        state_next = RUN;
                        per_next   = LEN_W'(1);
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (per_cnt == len_eff) begin
                            if (!fifo_empty) begin
                                pop       = 1'b1;
                                mark_next = head.mark;
                                len_next  = LEN_W'(head.len);
                                per_next  = LEN_W'(1);
                            end else begin
                                state_next = IDLE;
                                per_next   = '0;
                            end
                        end else begin
                            per_next = per_cnt + LEN_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A push is also taken while full when the head leaves in the same cycle.
    assign push          = In_Burst_Valid & In_Enable & (ready_q | (fifo_full & pop));
    assign push_rec.mark = In_Burst_Mark;
    assign push_rec.len  = BURST_LEN_W'(In_Burst_Len);

    ir_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (burst_t)
    ) u_fifo (
        .clk          (In_Clock),
        .rst          (In_Reset),
        .flush        (~In_Enable),
        .push         (push),
        .push_data    (push_rec),
        .pop          (pop),
        .head_c       (head),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .empty_next_c (empty_next),
        .full_next_c  (full_next)
    );

    always_ff @(posedge In_Clock) begin
        if (In_Reset) begin
            state   <= IDLE;
            mark_q  <= 1'b0;
            len_q   <= '0;
            per_cnt <= '0;
            ir_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            mark_q  <= mark_next;
            len_q   <= len_next;
            per_cnt <= per_next;
            ir_q    <= phase_next & mark_next & (state_next == RUN);
            ready_q <= In_Enable & ~full_next;
            busy_q  <= (state_next != IDLE) | ~empty_next;
        end
    end

    assign Out_Carrier     = phase;
    assign Out_Ir          = ir_q;
    assign Out_Busy        = busy_q;
    assign Out_Burst_Ready = ready_q;

endmodule

// File: tb/tb_ir_carrier_gen.sv
// Scoreboard bench for ir_carrier_gen: directed scenarios followed by random bursts.
module tb_ir_carrier_gen;

    localparam int DEPTH = 4;
    localparam int RH    = 694;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] hdiv;
    logic        bv;
    logic        bm;
    logic [15:0] bl;
    logic        ready;
    logic        carrier;
    logic        ir;
    logic        busy;

    ir_carrier_gen dut (
        .In_Clock        (clk),
        .In_Reset        (rst),
        .In_Enable       (en),
        .In_Half_Div     (hdiv),
        .In_Burst_Valid  (bv),
        .In_Burst_Mark   (bm),
        .In_Burst_Len    (bl),
        .Out_Burst_Ready (ready),
        .Out_Carrier     (carrier),
        .Out_Ir          (ir),
        .Out_Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit mark;
        int len;
    } burst_s;

    typedef struct packed {
        logic car;
        logic ir;
        logic busy;
        logic ready;
    } exp_t;

    // Reference model: queue of bursts plus the burst in progress, advanced one clock at a time.
    burst_s bq[$];
    exp_t   expq[$];
    int     m_h;
    int     m_cnt;
    bit     m_ph;
    bit     cur_loaded;
    bit     cur_running;
    bit     cur_mark;
    int     cur_len;
    int     periods_done;
    bit     m_ready;

    int vectors;
    int miscompares;
    int ir_hi;
    int car_hi;
    int cyc;
    exp_t mon_e;
    exp_t mon_got;

    task automatic model_step(output bit accepted);
        bit     wrap;
        bit     bnd;
        bit     pop;
        bit     was_full;
        int     heff;
        burst_s b;
        exp_t   e;
        accepted = 1'b0;
        if (rst) begin
            m_h = RH; m_cnt = 0; m_ph = 1'b0;
            bq.delete();
            cur_loaded = 1'b0; cur_running = 1'b0; cur_mark = 1'b0;
            cur_len = 1; periods_done = 0; m_ready = 1'b0;
        end else if (!en) begin
            m_cnt = 0; m_ph = 1'b0;
            bq.delete();
            cur_loaded = 1'b0; cur_running = 1'b0; periods_done = 0;
            m_ready = 1'b0;
        end else begin
            heff     = (m_h == 0) ? 1 : m_h;
            wrap     = (m_cnt == heff - 1);
            bnd      = wrap && !m_ph;
            was_full = (bq.size() == DEPTH);
            pop      = 1'b0;
            if (!cur_loaded) begin
                if (bq.size() > 0) pop = 1'b1;
            end else if (!cur_running) begin
                if (bnd) begin
                    cur_running  = 1'b1;
                    periods_done = 1;
                end
            end else if (bnd) begin
                if (periods_done >= cur_len) begin
                    if (bq.size() > 0) pop = 1'b1;
                    else begin
                        cur_loaded  = 1'b0;
                        cur_running = 1'b0;
                    end
                end else begin
                    periods_done++;
                end
            end
            if (pop) begin
                b = bq.pop_front();
                cur_mark     = b.mark;
                cur_len      = (b.len == 0) ? 1 : b.len;
                cur_loaded   = 1'b1;
                periods_done = cur_running ? 1 : 0;
            end
            if (bv && (m_ready || (was_full && pop))) begin
                b.mark = bm;
                b.len  = int'(bl);
                bq.push_back(b);
                accepted = 1'b1;
            end
            if (wrap) begin
                if (!m_ph) m_h = int'(hdiv);
                m_cnt = 0;
                m_ph  = !m_ph;
            end else begin
                m_cnt++;
            end
            m_ready = (bq.size() != DEPTH);
        end
        e.car   = m_ph;
        e.ir    = m_ph && cur_mark && cur_running;
        e.busy  = cur_loaded || (bq.size() > 0);
        e.ready = m_ready;
        expq.push_back(e);
    endtask

    task automatic tick(output bit acc);
        model_step(acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        bv = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic push_burst(input bit m, input int l);
        bit acc;
        bv = 1'b1; bm = m; bl = 16'(l);
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) tick(acc);
        bv = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL push_accept: burst mark=%0d len=%0d not accepted within 200 cycles", m, l);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: one expectation per clock, compared just after the active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (expq.size() > 0) begin
            mon_e   = expq.pop_front();
            mon_got = {carrier, ir, busy, ready};
            vectors++;
            if (mon_got !== mon_e) begin
                miscompares++;
                $display("FAIL outputs cycle %0d {carrier,ir,busy,ready}: got %b expected %b",
                         cyc, mon_got, mon_e);
            end
            if (ir === 1'b1)      ir_hi++;
            if (carrier === 1'b1) car_hi++;
        end
    end

    initial begin
        int  c0;
        int  n_off;
        bit  acc;
        vectors = 0; miscompares = 0; ir_hi = 0; car_hi = 0; cyc = 0;
        rst = 1'b1; en = 1'b0; hdiv = 12'd3; bv = 1'b0; bm = 1'b0; bl = '0;
        @(negedge clk);
        idle(2);
        check_eq("reset_outputs", int'({carrier, ir, busy, ready}), 0);

        // Carrier only, first half uses the reset divider.
        rst = 1'b0; en = 1'b1;
        idle(700);
        c0 = car_hi;
        idle(60);
        check_eq("carrier_h3_high_cycles", car_hi - c0, 30);

        c0 = ir_hi;
        push_burst(1'b1, 2);
        idle(40);
        check_eq("single_mark_ir_cycles", ir_hi - c0, 6);
        check_eq("single_mark_busy_after", int'(busy), 0);

        c0 = ir_hi;
        push_burst(1'b1, 2);
        push_burst(1'b0, 1);
        push_burst(1'b1, 1);
        idle(60);
        check_eq("chain_ir_cycles", ir_hi - c0, 9);

        // Fill the queue behind a running burst, then push into the freeing slot.
        push_burst(1'b1, 3);
        idle(2);
        for (int i = 0; i < DEPTH; i++) push_burst(1'b1, 1);
        idle(1);
        check_eq("full_ready_low", int'(ready), 0);
        push_burst(1'b0, 2);
        check_eq("full_ready_after_swap", int'(ready), 0);
        idle(80);
        check_eq("drained_busy", int'(busy), 0);

        idle(4);
        hdiv = 12'd5;
        idle(60);
        c0 = car_hi;
        idle(100);
        check_eq("carrier_h5_high_cycles", car_hi - c0, 50);
        hdiv = 12'd3;
        idle(30);

        // Reset during a mark, with a push offered in the same cycle.
        push_burst(1'b1, 10);
        idle(15);
        rst = 1'b1; bv = 1'b1; bm = 1'b1; bl = 16'd2;
        tick(acc);
        rst = 1'b0; bv = 1'b0;
        check_eq("reset_mid_mark_ir", int'(ir), 0);
        check_eq("reset_mid_mark_busy", int'(busy), 0);
        idle(710);

        push_burst(1'b1, 10);
        idle(15);
        en = 1'b0;
        idle(2);
        check_eq("disable_mid_mark_ir", int'(ir), 0);
        check_eq("disable_mid_mark_busy", int'(busy), 0);
        en = 1'b1;
        idle(20);

        // Random traffic with divider changes and enable drops.
        n_off = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) hdiv = 12'($urandom_range(0, 4));
            if (n_off > 0) begin
                n_off--;
                en = (n_off == 0);
            end else if ($urandom_range(0, 199) == 0) begin
                n_off = $urandom_range(1, 3);
                en    = 1'b0;
            end
            bv = ($urandom_range(0, 3) == 0);
            bm = 1'($urandom_range(0, 1));
            bl = 16'($urandom_range(0, 3));
            tick(acc);
        end
        en = 1'b1;
        idle(5);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ir_carrier_gen.md
IR_CARRIER_GEN -- requirements
Module: ir_carrier_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 12, width of the half-period divider.
REQ-002 SHALL have parameter LEN_W, default 16, width of the burst length in carrier periods.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of queued bursts (power of two, >=2).
REQ-004 SHALL have parameter RESET_HALF, default 694, half-period loaded at reset (50 MHz / 36 kHz / 2).
REQ-005 SHALL have port In_Clock, input, 1, the single clock.
REQ-006 SHALL have port In_Reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port In_Enable, input, 1, run enable.
REQ-008 SHALL have port In_Half_Div, input, DIV_W, carrier half-period in In_Clock cycles.
REQ-009 SHALL have port In_Burst_Valid, input, 1, burst push request.
REQ-010 SHALL have port In_Burst_Mark, input, 1, 1 = carrier on, 0 = silent space.
REQ-011 SHALL have port In_Burst_Len, input, LEN_W, burst length in carrier periods.
REQ-012 SHALL have port Out_Burst_Ready, output, 1, FIFO can accept a burst.
REQ-013 SHALL have port Out_Carrier, output, 1, free-running carrier square wave.
REQ-014 SHALL have port Out_Ir, output, 1, gated IR drive (carrier during marks).
REQ-015 SHALL have port Out_Busy, output, 1, burst active or queued.

Function
REQ-016 Carrier: half counter counts 0..H-1, then toggles phase and clears; H = In_Half_Div, sampled only at period boundaries; H = 0 treated as 1.
REQ-017 Period boundary = cycle in which phase toggles 0->1; Out_Carrier = phase, registered.
REQ-018 Push accepted when In_Burst_Valid & Out_Burst_Ready; Out_Burst_Ready = In_Enable & !full.
REQ-019 Simultaneous push and pop when full SHALL both take effect; count unchanged.
REQ-020 FSM states: IDLE, ARMED, RUN.
REQ-021 IDLE -> ARMED: FIFO non-empty; pop head into mark/len registers in the same cycle.
REQ-022 ARMED -> RUN: at next period boundary; period counter = 1.
REQ-023 RUN: increment period counter at each boundary; when counter == len at a boundary, pop the next burst and stay in RUN (counter = 1, no gap) if FIFO non-empty; otherwise go to IDLE.
REQ-024 Len 0 SHALL be treated as 1.
REQ-025 Out_Ir = phase & mark & (state == RUN), registered; first high cycle coincides with the Out_Carrier rise at burst start.
REQ-026 Out_Busy = (state != IDLE) | FIFO non-empty.
REQ-027 In_Enable low: carrier counter and phase held at 0, FSM forced to IDLE, FIFO flushed, Out_Ir = 0, pushes refused.
REQ-028 Counter arithmetic SHALL be unsigned, DIV_W and LEN_W wide, with no wrap beyond the terminal compare.

Reset
REQ-029 Reset SHALL set: H = RESET_HALF, counters 0, phase 0, FSM IDLE, FIFO empty.
REQ-030 Reset SHALL drive all outputs 0 in the following cycle.
REQ-031 Reset mid-burst SHALL abort the burst with no residual Out_Ir pulse.
REQ-032 Reset SHALL override In_Enable and pushes.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the burst record typedef (mark, len), and RESET_HALF.
REQ-034 The burst queue SHALL be a sub-module ir_burst_fifo, parametrised by depth and record type.

Verification
REQ-035 H=3, enable, no bursts -> Out_Carrier period 6 cycles, 3 high; Out_Ir 0; Out_Busy 0.
REQ-036 Push (mark=1, len=2) -> Out_Ir high 3 cycles, low 3 cycles, twice from the next boundary; then IDLE; Out_Busy drops.
REQ-037 Push mark/len=2, space/len=1, mark/len=1 back-to-back -> 12 cycles pulses, 6 silent cycles, 6 cycles pulse, no gaps between bursts.
REQ-038 Fill 4 bursts -> Out_Burst_Ready 0; push during pop -> accepted; occupancy stays 4.
REQ-039 Change H 3->5 mid-period -> new 10-cycle period begins only after the current boundary.
REQ-040 Assert In_Reset during a mark, then separately drop In_Enable during a mark -> Out_Ir 0 next cycle; FIFO empty; FSM IDLE.
